// File: rtl/note_slot_scheduler.sv
// Note-slot pool for the falling-note lanes: spawns pattern entries on beats,
// sweeps slots on move ticks and button hits, and exposes slots via a read mux.
module note_slot_scheduler #(
  parameter int NUM_SLOTS = 8,
  parameter int Y_START   = 0,
  parameter int Y_END     = 479,
  parameter int STEP      = 1,
  parameter int HIT_Y_LO  = 400,
  parameter int HIT_Y_HI  = 460
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         beat_tick,
  input  logic                         move_tick,
  input  logic [2:0]                   hit_lane,
  input  logic [$clog2(NUM_SLOTS)-1:0] rd_idx,
  output logic                         rd_valid,
  output logic [1:0]                   rd_lane,
  output logic [9:0]                   rd_y,
  output logic [1:0]                   state,
  output logic [2:0]                   pattern_idx,
  output logic [7:0]                   hit_count,
  output logic [7:0]                   miss_count,
  output logic                         overflow
);
  localparam int IDXW = $clog2(NUM_SLOTS);
  localparam int CNTW = (IDXW > 2) ? IDXW : 2;
  localparam logic [9:0]      Y_START_W  = 10'(Y_START);
  localparam logic [10:0]     Y_END_W    = 11'(Y_END);
  localparam logic [10:0]     STEP_W     = 11'(STEP);
  localparam logic [9:0]      HIT_LO_W   = 10'(HIT_Y_LO);
  localparam logic [9:0]      HIT_HI_W   = 10'(HIT_Y_HI);
  localparam logic [CNTW-1:0] SWEEP_LAST = CNTW'(NUM_SLOTS - 1);
  localparam logic [CNTW-1:0] SPAWN_LAST = CNTW'(2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_SPAWN = 2'b10,
    ST_SWEEP = 2'b11
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [NUM_SLOTS-1:0] r_valid;
  logic [1:0]           r_lane [NUM_SLOTS];
  logic [9:0]           r_y    [NUM_SLOTS];
  logic [CNTW-1:0]      r_cnt;
  logic [2:0]           r_pattern_idx;
  logic [7:0]           r_hit_count;
  logic [7:0]           r_miss_count;
  logic                 r_beat_pend;
  logic                 r_move_pend;
  logic [2:0]           r_hit_pend;
  logic                 r_hit_mode;
  logic [1:0]           r_hit_target;
  logic                 r_hit_done;

  logic [2:0]           w_mask;
  logic                 w_lane_bit;
  logic                 w_free_found;
  logic [IDXW-1:0]      w_free_idx;
  logic [IDXW-1:0]      w_cur_idx;
  logic [10:0]          w_y_sum;
  logic [NUM_SLOTS-1:0] w_in_window;
  logic                 w_hit_now;
  logic                 w_spawn_lane_on;
  logic                 w_spawn_write;
  logic                 w_start_spawn;
  logic                 w_start_move;
  logic                 w_start_hit;
  logic [1:0]           w_hit_sel;
  logic [2:0]           w_hit_clr;

  always_comb begin
    case (r_pattern_idx)
      3'd0:    w_mask = 3'b000;
      3'd1:    w_mask = 3'b001;
      3'd2:    w_mask = 3'b010;
      3'd3:    w_mask = 3'b100;
      3'd4:    w_mask = 3'b001;
      3'd5:    w_mask = 3'b010;
      3'd6:    w_mask = 3'b100;
      default: w_mask = 3'b111;
    endcase
  end

  // Spawn cycle n handles lane n: 0 blue, 1 green, 2 red.
  always_comb begin
    case (r_cnt[1:0])
      2'd0:    w_lane_bit = w_mask[0];
      2'd1:    w_lane_bit = w_mask[1];
      2'd2:    w_lane_bit = w_mask[2];
      default: w_lane_bit = 1'b0;
    endcase
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDXW'(i);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_window
      assign w_in_window[gi] = r_valid[gi] && (r_lane[gi] == r_hit_target) &&
                               (r_y[gi] >= HIT_LO_W) && (r_y[gi] <= HIT_HI_W);
    end
  endgenerate

  assign w_cur_idx       = r_cnt[IDXW-1:0];
  assign w_y_sum         = {1'b0, r_y[w_cur_idx]} + STEP_W;
  assign w_hit_now       = !r_hit_done && w_in_window[w_cur_idx];
  assign w_spawn_lane_on = !reset && start && (r_state == ST_SPAWN) && w_lane_bit;
  assign w_spawn_write   = w_spawn_lane_on && w_free_found;

  always_comb begin
    w_state_next  = r_state;
    w_start_spawn = 1'b0;
    w_start_move  = 1'b0;
    w_start_hit   = 1'b0;
    w_hit_sel     = 2'd0;
    w_hit_clr     = 3'b000;
    if (r_hit_pend[0]) begin
      w_hit_sel = 2'd0;
      w_hit_clr = 3'b001;
    end else if (r_hit_pend[1]) begin
      w_hit_sel = 2'd1;
      w_hit_clr = 3'b010;
    end else if (r_hit_pend[2]) begin
      w_hit_sel = 2'd2;
      w_hit_clr = 3'b100;
    end
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN: begin
        if (|r_hit_pend) begin
          w_state_next = ST_SWEEP;
          w_start_hit  = 1'b1;
        end else if (r_beat_pend) begin
          w_state_next  = ST_SPAWN;
          w_start_spawn = 1'b1;
        end else if (r_move_pend) begin
          w_state_next = ST_SWEEP;
          w_start_move = 1'b1;
        end
      end
      ST_SPAWN: if (r_cnt == SPAWN_LAST) w_state_next = ST_RUN;
      ST_SWEEP: if (r_cnt == SWEEP_LAST) w_state_next = ST_RUN;
      default:  w_state_next = ST_IDLE;
    endcase
    if (!start) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_lane[i] <= 2'd0;
        r_y[i]    <= 10'd0;
      end
      r_cnt         <= '0;
      r_pattern_idx <= 3'd0;
      r_hit_count   <= 8'd0;
      r_miss_count  <= 8'd0;
      r_beat_pend   <= 1'b0;
      r_move_pend   <= 1'b0;
      r_hit_pend    <= 3'b000;
      r_hit_mode    <= 1'b0;
      r_hit_target  <= 2'd0;
      r_hit_done    <= 1'b0;
    end else if (!start) begin
      // Abort: counters and pattern position are kept for the display.
      r_valid     <= '0;
      r_cnt       <= '0;
      r_beat_pend <= 1'b0;
      r_move_pend <= 1'b0;
      r_hit_pend  <= 3'b000;
      r_hit_done  <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_cnt         <= '0;
      r_pattern_idx <= 3'd0;
      r_hit_count   <= 8'd0;
      r_miss_count  <= 8'd0;
      r_beat_pend   <= 1'b0;
      r_move_pend   <= 1'b0;
      r_hit_pend    <= 3'b000;
    end else begin
      r_beat_pend <= (r_beat_pend | beat_tick) & ~w_start_spawn;
      r_move_pend <= (r_move_pend | move_tick) & ~w_start_move;
      r_hit_pend  <= (r_hit_pend | hit_lane) & ~w_hit_clr_gated(w_start_hit, w_hit_clr);
      case (r_state)
        ST_RUN: begin
          r_cnt <= '0;
          if (w_start_hit) begin
            r_hit_mode   <= 1'b1;
            r_hit_target <= w_hit_sel;
            r_hit_done   <= 1'b0;
          end else if (w_start_move) begin
            r_hit_mode <= 1'b0;
          end
        end
        ST_SPAWN: begin
          r_cnt <= r_cnt + CNTW'(1);
          if (w_spawn_write) begin
            r_valid[w_free_idx] <= 1'b1;
            r_lane[w_free_idx]  <= r_cnt[1:0];
            r_y[w_free_idx]     <= Y_START_W;
          end
          if (r_cnt == SPAWN_LAST) begin
            r_cnt         <= '0;
            r_pattern_idx <= r_pattern_idx + 3'd1;
          end
        end
        ST_SWEEP: begin
          r_cnt <= r_cnt + CNTW'(1);
          if (r_hit_mode) begin
            if (w_hit_now) begin
              r_valid[w_cur_idx] <= 1'b0;
              r_hit_done         <= 1'b1;
              if (r_hit_count != 8'hFF) r_hit_count <= r_hit_count + 8'd1;
            end
          end else if (r_valid[w_cur_idx]) begin
            if (w_y_sum > Y_END_W) begin
              r_valid[w_cur_idx] <= 1'b0;
              if (r_miss_count != 8'hFF) r_miss_count <= r_miss_count + 8'd1;
            end else begin
              r_y[w_cur_idx] <= w_y_sum[9:0];
            end
          end
          if (r_cnt == SWEEP_LAST) r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [2:0] w_hit_clr_gated(input logic en, input logic [2:0] clr);
    return en ? clr : 3'b000;
  endfunction

  assign rd_valid    = r_valid[rd_idx];
  assign rd_lane     = r_lane[rd_idx];
  assign rd_y        = r_y[rd_idx];
  assign state       = r_state;
  assign pattern_idx = r_pattern_idx;
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;
  assign overflow    = w_spawn_lane_on && !w_free_found;

endmodule

// File: tb/tb_note_slot_scheduler.sv
// Directed bench for note_slot_scheduler: a vector table of tick bursts with
// expected slot/counter state, plus hand sequences for overflow and abort.
module tb_note_slot_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       beat_tick;
  logic       move_tick;
  logic [2:0] hit_lane;
  logic [2:0] rd_idx;
  logic       rd_valid;
  logic [1:0] rd_lane;
  logic [9:0] rd_y;
  logic [1:0] state;
  logic [2:0] pattern_idx;
  logic [7:0] hit_count;
  logic [7:0] miss_count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  note_slot_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .beat_tick  (beat_tick),
    .move_tick  (move_tick),
    .hit_lane   (hit_lane),
    .rd_idx     (rd_idx),
    .rd_valid   (rd_valid),
    .rd_lane    (rd_lane),
    .rd_y       (rd_y),
    .state      (state),
    .pattern_idx(pattern_idx),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .overflow   (overflow)
  );

  typedef struct {
    logic       start;
    logic       beat;
    logic       move;
    logic [2:0] hit;
    int         reps;
    int         gap;
    logic [2:0] idx;
    logic [1:0] e_state;
    logic       e_valid;
    logic [1:0] e_lane;
    logic [9:0] e_y;
    logic [2:0] e_pat;
    logic [7:0] e_hit;
    logic [7:0] e_miss;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s tag=%0d got=%0d want=%0d", name, tag, act, exp);
    end
    $display("check %s tag=%0d got=%0d want=%0d", name, tag, act, exp);
  endtask

  int         ovf_seen;
  int         ovf_beat;
  int         ovf_cyc;
  logic [1:0] ovf_state;
  logic [1:0] exp_lane [8];

  initial begin
    //            st    bt    mv    hit     reps gap idx  state  v     lane  y        pat   hit   miss
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1,   2,  3'd0, 2'b01, 1'b0, 2'd0, 10'd0,   3'd0, 8'd0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1,   50, 3'd0, 2'b01, 1'b0, 2'd0, 10'd0,   3'd1, 8'd0, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1,   5,  3'd0, 2'b01, 1'b1, 2'd0, 10'd0,   3'd2, 8'd0, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 3'b000, 399, 12, 3'd0, 2'b01, 1'b1, 2'd0, 10'd399, 3'd2, 8'd0, 8'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'b001, 1,   12, 3'd0, 2'b01, 1'b1, 2'd0, 10'd399, 3'd2, 8'd0, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'b000, 21,  12, 3'd0, 2'b01, 1'b1, 2'd0, 10'd420, 3'd2, 8'd0, 8'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'b010, 1,   12, 3'd0, 2'b01, 1'b1, 2'd0, 10'd420, 3'd2, 8'd0, 8'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'b001, 1,   12, 3'd0, 2'b01, 1'b0, 2'd0, 10'd0,   3'd2, 8'd1, 8'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1,   12, 3'd0, 2'b01, 1'b1, 2'd1, 10'd0,   3'd3, 8'd1, 8'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 3'b000, 479, 12, 3'd0, 2'b01, 1'b1, 2'd1, 10'd479, 3'd3, 8'd1, 8'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 3'b000, 1,   12, 3'd0, 2'b01, 1'b0, 2'd0, 10'd0,   3'd3, 8'd1, 8'd1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 3'b000, 1,   12, 3'd0, 2'b01, 1'b1, 2'd2, 10'd0,   3'd4, 8'd1, 8'd1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 3'b000, 460, 12, 3'd0, 2'b01, 1'b1, 2'd2, 10'd460, 3'd4, 8'd1, 8'd1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 3'b100, 1,   12, 3'd0, 2'b01, 1'b0, 2'd0, 10'd0,   3'd4, 8'd2, 8'd1};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 3'b000, 1,   12, 3'd0, 2'b01, 1'b1, 2'd0, 10'd0,   3'd5, 8'd2, 8'd1};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 3'b000, 461, 12, 3'd0, 2'b01, 1'b1, 2'd0, 10'd461, 3'd5, 8'd2, 8'd1};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 3'b001, 1,   12, 3'd0, 2'b01, 1'b1, 2'd0, 10'd461, 3'd5, 8'd2, 8'd1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 3'b000, 1,   2,  3'd0, 2'b00, 1'b0, 2'd0, 10'd0,   3'd5, 8'd2, 8'd1};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 3'b000, 1,   2,  3'd0, 2'b01, 1'b0, 2'd0, 10'd0,   3'd0, 8'd0, 8'd0};

    exp_lane[0] = 2'd0; exp_lane[1] = 2'd1; exp_lane[2] = 2'd2; exp_lane[3] = 2'd0;
    exp_lane[4] = 2'd1; exp_lane[5] = 2'd2; exp_lane[6] = 2'd0; exp_lane[7] = 2'd1;

    // Reset held with start high and ticks toggling.
    reset = 1'b1; start = 1'b1; beat_tick = 1'b0; move_tick = 1'b0;
    hit_lane = 3'b000; rd_idx = 3'd0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      beat_tick = c[0];
      move_tick = ~c[0];
      hit_lane  = 3'(c);
    end
    chk("reset_state", 0, state, 2'b00);
    chk("reset_pattern", 0, pattern_idx, 3'd0);
    chk("reset_hit", 0, hit_count, 8'd0);
    chk("reset_miss", 0, miss_count, 8'd0);
    chk("reset_overflow", 0, overflow, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      chk("reset_rd_valid", i, rd_valid, 1'b0);
      chk("reset_rd_lane", i, rd_lane, 2'd0);
      chk("reset_rd_y", i, rd_y, 10'd0);
    end
    beat_tick = 1'b0; move_tick = 1'b0; hit_lane = 3'b000; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < NV; v++) begin
      start = vecs[v].start;
      for (int r = 0; r < vecs[v].reps; r++) begin
        beat_tick = vecs[v].beat;
        move_tick = vecs[v].move;
        hit_lane  = vecs[v].hit;
        @(posedge clk); #1;
        beat_tick = 1'b0; move_tick = 1'b0; hit_lane = 3'b000;
        repeat (vecs[v].gap) @(posedge clk);
        #1;
      end
      rd_idx = vecs[v].idx;
      #1;
      chk("vec_state", v, state, vecs[v].e_state);
      chk("vec_rd_valid", v, rd_valid, vecs[v].e_valid);
      chk("vec_pattern", v, pattern_idx, vecs[v].e_pat);
      chk("vec_hit", v, hit_count, vecs[v].e_hit);
      chk("vec_miss", v, miss_count, vecs[v].e_miss);
      if (vecs[v].e_valid) begin
        chk("vec_rd_lane", v, rd_lane, vecs[v].e_lane);
        chk("vec_rd_y", v, rd_y, vecs[v].e_y);
      end
    end

    // Eight beats from entry 0 fill the pool; entry 7's red note overflows.
    ovf_seen = 0; ovf_beat = -1; ovf_cyc = -1; ovf_state = 2'b00;
    for (int b = 0; b < 8; b++) begin
      beat_tick = 1'b1;
      @(posedge clk); #1;
      beat_tick = 1'b0;
      for (int c = 1; c <= 12; c++) begin
        @(posedge clk); #1;
        if (overflow) begin
          ovf_seen++;
          ovf_beat  = b;
          ovf_cyc   = c;
          ovf_state = state;
        end
      end
    end
    chk("ovf_pulses", 0, ovf_seen, 1);
    chk("ovf_beat", 0, ovf_beat, 7);
    chk("ovf_cycle", 0, ovf_cyc, 3);
    chk("ovf_state", 0, ovf_state, 2'b10);
    chk("fill_pattern_wrap", 0, pattern_idx, 3'd0);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      chk("fill_rd_valid", i, rd_valid, 1'b1);
      chk("fill_rd_lane", i, rd_lane, exp_lane[i]);
      chk("fill_rd_y", i, rd_y, 10'd0);
    end

    // Drop start during the third cycle of a move sweep.
    move_tick = 1'b1;
    @(posedge clk); #1;
    move_tick = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_sweep", 0, state, 2'b11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort_state", 0, state, 2'b00);
    chk("abort_hit", 0, hit_count, 8'd0);
    chk("abort_miss", 0, miss_count, 8'd0);
    chk("abort_pattern", 0, pattern_idx, 3'd0);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      chk("abort_rd_valid", i, rd_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/note_slot_scheduler.md
# note_slot_scheduler

Sequencing controller for the falling-note lanes of the VGA rhythm game. It walks a fixed note pattern on each beat and allocates note slots from a shared pool to the red, green and blue lanes. On each move tick it advances every live slot's vertical position, and it retires slots on a hit or a miss. The VGA pixel logic reads slot state through a combinational read port; the LED and SSD logic use the counters and state.

## Interface
Parameters:
- NUM_SLOTS, 8: size of the shared note-slot pool (power of 2, at most 16).
- Y_START, 0: spawn row of a new note.
- Y_END, 479: last visible row. A note whose new y exceeds this row is missed.
- STEP, 1: rows advanced per move tick.
- HIT_Y_LO, 400: lower bound of the hit window, inclusive.
- HIT_Y_HI, 460: upper bound of the hit window, inclusive.

Ports:
- clk, input, 1: system clock. All logic is on its rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: level signal; 1 runs the game, 0 forces IDLE.
- beat_tick, input, 1: one-cycle pulse that spawns the next pattern entry.
- move_tick, input, 1: one-cycle pulse that advances all live notes.
- hit_lane, input, 3: one-cycle pulses from debounced buttons. Bit 2 is red, bit 1 green, bit 0 blue.
- rd_idx, input, log2(NUM_SLOTS): slot select for the renderer.
- rd_valid, output, 1: the selected slot is live (combinational).
- rd_lane, output, 2: lane of the selected slot. 0 is blue, 1 green, 2 red (combinational).
- rd_y, output, 10: center row of the selected slot (combinational).
- state, output, 2: 00 IDLE, 01 RUN, 10 SPAWN, 11 SWEEP.
- pattern_idx, output, 3: index of the next pattern entry.
- hit_count, output, 8: hits since start, saturating at 255.
- miss_count, output, 8: misses since start, saturating at 255.
- overflow, output, 1: one-cycle pulse when a spawn is dropped because the pool is full.

## Operation
- Pattern ROM: 8 entries of 3-bit lane masks, bit order matching hit_lane. Contents by index: 000, 001, 010, 100, 001, 010, 100, 111.
- Each slot holds valid (1 bit), lane (2 bits) and y (10 bits).
- Pending flags:
  - beat_pend, move_pend and hit_pend[2:0] are set by their pulses in any non-IDLE state.
  - A pulse arriving while its flag is already set is coalesced (lost).
  - A flag clears when its work begins.
- IDLE:
  - All slots are invalid and all pending flags are clear.
  - start=1 moves to RUN, clears hit_count, miss_count and pattern_idx, and clears all pending flags.
- RUN, one decision per cycle. Priority order:
  - Any hit_pend bit: go to SWEEP in hit mode for the lowest-numbered pending lane; clear that bit only.
  - beat_pend: go to SPAWN.
  - move_pend: go to SWEEP in move mode.
- SPAWN, exactly 3 cycles, one per lane (blue, then green, then red):
  - If the mask bit for that lane is set, take the lowest-index free slot and write valid=1, that lane, y=Y_START.
  - If no slot is free, pulse overflow and drop that note.
  - In the last cycle, pattern_idx increments (wrapping 7 to 0); return to RUN.
- SWEEP in move mode, NUM_SLOTS cycles, slot i on cycle i:
  - Live slot: compute y+STEP in 11 bits.
  - If the result exceeds Y_END, clear valid and increment miss_count (saturating); otherwise store it.
- SWEEP in hit mode, NUM_SLOTS cycles:
  - The first slot in index order that is live, in the target lane, and has HIT_Y_LO ≤ y ≤ HIT_Y_HI is cleared and increments hit_count (saturating).
  - At most one slot is cleared per press.
  - If no slot matches, nothing changes.
- After NUM_SLOTS cycles, SWEEP returns to RUN.
- start=0 in any state goes to IDLE on the next edge, aborting any sweep or spawn in progress.
  - All slots are invalidated and pending flags cleared.
  - hit_count, miss_count and pattern_idx hold until the next start.
- The read port is a pure mux of slot registers and is valid in every state.

## Timing
- Reset values:
  - state=00; slots all invalid (rd_valid=0, rd_lane=0, rd_y=0 for every index).
  - pattern_idx=0, hit_count=0, miss_count=0, overflow=0, all pending flags clear.
- Reset overrides start and all ticks in the same cycle.
- Latency from a tick to the first slot write: 1 cycle to latch the pending flag, 1 cycle for the RUN decision, then the write on the next edge.
- SPAWN occupies 3 cycles. SWEEP occupies NUM_SLOTS cycles.
- Worst case to drain all pending work: 3×(NUM_SLOTS+1) + 4 + (NUM_SLOTS+1) cycles. The tick rates in the top level leave more than 1000 cycles between ticks.
- overflow is asserted in the SPAWN cycle of the dropped lane only.
- Counter and slot updates made in a given cycle are visible on the outputs the following cycle.

## Test plan
- Reset with start=1 and ticks toggling → state=00; for rd_idx 0..7, rd_valid=0; counts=0; overflow=0.
- start=1, then two beat_ticks spaced 50 cycles apart:
  - Entry 0 (000) spawns nothing and pattern_idx becomes 1.
  - After the second beat, slot 0 reads valid=1, lane=0, y=0 within 5 cycles; pattern_idx=2.
- With one live note, 480 move_ticks:
  - After tick 479, rd_y=479 and rd_valid=1.
  - After tick 480, rd_valid=0 and miss_count=1.
- Blue note advanced to y=420, hit_lane=001 → within NUM_SLOTS+3 cycles, the slot is invalid and hit_count=1.
  - The same press at y=399 → no change.
  - hit_lane=010 at y=420 → no change.
- Eight consecutive beats from pattern_idx=0:
  - Slots 0–7 fill.
  - overflow pulses once, in the red-lane cycle of entry 7.
  - pattern_idx wraps to 0.
- start dropped in the third cycle of a move SWEEP → state=00 the next cycle; all rd_valid=0; hit_count and miss_count unchanged.
